// File: rtl/addsub_digit_serial.sv
// Digit-serial unsigned adder/subtractor with optional saturation.
// A request is captured in IDLE, processed DIGIT bits per cycle in RUN
// (LSB digit first), and the result is finalised and held in DONE until
// the consumer accepts it.
//
// state | meaning
// IDLE  | waiting for a request, in_ready=1
// RUN   | one digit per cycle, N = WIDTH/DIGIT cycles
// DONE  | first cycle finalises outputs, then held until out_ready
module addsub_digit_serial #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             sat,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_digit
    $error("addsub_digit_serial: WIDTH must be a positive multiple of DIGIT");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] bx_r;   // b already conditioned for subtract (~b)
  logic [WIDTH-1:0] acc;    // raw sum digits, filled LSB digit first
  logic             sub_r;
  logic             sat_r;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [DIGIT-1:0] da;
  logic [DIGIT-1:0] db;
  logic [DIGIT:0]   dsum;
  logic             ovf_raw;
  int               base;

  assign in_ready = (state == IDLE);

  // Select the current digit of both operands and add it with the running carry.
  always_comb begin
    base    = int'(cnt) * DIGIT;
    da      = a_r[base +: DIGIT];
    db      = bx_r[base +: DIGIT];
    dsum    = {1'b0, da} + {1'b0, db} + {{DIGIT{1'b0}}, carry};
    ovf_raw = sub_r ? ~carry : carry;
  end

  // Control FSM with operand capture, digit datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_r       <= '0;
      bx_r      <= '0;
      acc       <= '0;
      sub_r     <= 1'b0;
      sat_r     <= 1'b0;
      carry     <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            bx_r  <= sub ? ~b : b;
            sub_r <= sub;
            sat_r <= sat;
            carry <= cin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          acc[base +: DIGIT] <= dsum[DIGIT-1:0];
          carry              <= dsum[DIGIT];
          if (cnt == CW'(N - 1)) begin
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (!out_valid) begin
            // Final carry is settled; apply saturation and publish.
            cout      <= carry;
            ovf       <= ovf_raw;
            out_valid <= 1'b1;
            if (sat_r && ovf_raw)
              result <= sub_r ? '0 : '1;
            else
              result <= acc;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_digit_serial.sv
// Self-checking bench: two instances (8b/2-bit digits and 16b/1-bit digits)
// compared against an integer-arithmetic reference model.
module tb_addsub_digit_serial;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        iv8 = 0, ir8, sub8 = 0, sat8 = 0, cin8 = 0, ov8, or8 = 0, co8, of8;
  logic [7:0]  a8 = 0, b8 = 0, res8;
  logic        iv16 = 0, ir16, sub16 = 0, sat16 = 0, cin16 = 0, ov16, or16 = 0, co16, of16;
  logic [15:0] a16 = 0, b16 = 0, res16;

  int n_vec = 0;
  int n_err = 0;

  addsub_digit_serial #(.WIDTH(8), .DIGIT(2)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .sub(sub8), .sat(sat8), .cin(cin8), .out_valid(ov8), .out_ready(or8),
    .result(res8), .cout(co8), .ovf(of8));

  addsub_digit_serial #(.WIDTH(16), .DIGIT(1)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .sub(sub16), .sat(sat16), .cin(cin16), .out_valid(ov16), .out_ready(or16),
    .result(res16), .cout(co16), .ovf(of16));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: {ovf, cout, result[15:0]} from plain integer arithmetic.
  function automatic logic [17:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                        input logic sub, input logic sat, input logic cin);
    longint s, m;
    logic c, o;
    logic [15:0] r;
    m = (longint'(1) << w) - 1;
    if (!sub) begin
      s = longint'(a) + longint'(b) + longint'(cin);
      c = (s > m);
      o = c;
    end else begin
      s = longint'(a) - longint'(b) - (cin ? longint'(0) : longint'(1));
      c = (s >= 0);
      o = !c;
    end
    r = 16'(s & m);
    if (sat && o) r = sub ? 16'h0 : 16'(m);
    return {o, c, r};
  endfunction

  task automatic do8(input logic [7:0] a, input logic [7:0] b, input logic s, input logic t,
                     input logic c, input int hold);
    logic [17:0] e;
    int lat;
    e = model(8, {8'h0, a}, {8'h0, b}, s, t, c);
    @(negedge clk);
    check("idle8", ir8, 1);
    a8 = a; b8 = b; sub8 = s; sat8 = t; cin8 = c; iv8 = 1;
    @(posedge clk); #1;
    lat = 0;
    while (ov8 !== 1'b1 && lat < 60) begin
      iv8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
      sub8 = 1'($urandom); sat8 = 1'($urandom); cin8 = 1'($urandom); or8 = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    or8 = 0;
    check("lat8", 32'(lat), 5);
    check("res8", res8, e[7:0]);
    check("cout8", co8, e[16]);
    check("ovf8", of8, e[17]);
    check("busy8", ir8, 0);
    for (int i = 0; i < hold; i++) begin
      iv8 = 1; a8 = 8'($urandom); b8 = 8'($urandom);
      sub8 = 1'($urandom); sat8 = 1'($urandom); cin8 = 1'($urandom);
      @(posedge clk); #1;
      check("hold_res8", res8, e[7:0]);
      check("hold_flags8", {ov8, ir8, co8, of8}, {1'b1, 1'b0, e[16], e[17]});
    end
    iv8 = 0;
    @(negedge clk); or8 = 1;
    @(posedge clk); #1; or8 = 0;
    check("release8", {ov8, ir8}, 2'b01);
  endtask

  task automatic do16(input logic [15:0] a, input logic [15:0] b, input logic s, input logic t,
                      input logic c);
    logic [17:0] e;
    int lat;
    e = model(16, a, b, s, t, c);
    @(negedge clk);
    check("idle16", ir16, 1);
    a16 = a; b16 = b; sub16 = s; sat16 = t; cin16 = c; iv16 = 1;
    @(posedge clk); #1;
    iv16 = 0; a16 = 16'($urandom); b16 = 16'($urandom);
    lat = 0;
    while (ov16 !== 1'b1 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    check("lat16", 32'(lat), 17);
    check("res16", res16, e[15:0]);
    check("cout16", co16, e[16]);
    check("ovf16", of16, e[17]);
    @(negedge clk); or16 = 1;
    @(posedge clk); #1; or16 = 0;
    check("release16", {ov16, ir16}, 2'b01);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic seen;
    #1;
    check("rst_state8", {ir8, ov8, res8, co8, of8}, {1'b1, 1'b0, 8'h00, 1'b0, 1'b0});
    check("rst_state16", {ir16, ov16}, 2'b10);
    @(negedge clk); rst = 0;

    do8(8'h50, 8'h20, 1, 0, 1, 0);
    do8(8'h10, 8'h20, 1, 0, 1, 0);
    do8(8'h10, 8'h20, 1, 1, 1, 0);
    do8(8'hF0, 8'h20, 0, 0, 0, 0);
    do8(8'hF0, 8'h20, 0, 1, 0, 0);
    do8(8'h7F, 8'h00, 0, 0, 1, 0);
    do8(8'hA5, 8'h3C, 0, 0, 1, 6);
    do8(8'h3C, 8'hA5, 1, 0, 0, 0);

    // Reset in the second RUN cycle discards the transaction.
    @(negedge clk);
    a8 = 8'h50; b8 = 8'h20; sub8 = 1; sat8 = 0; cin8 = 1; iv8 = 1;
    @(posedge clk); #1; iv8 = 0;
    @(posedge clk); #2; rst = 1;
    #1;
    check("async_rst8", {ir8, ov8, res8, co8, of8}, {1'b1, 1'b0, 8'h00, 1'b0, 1'b0});
    #1; rst = 0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (ov8) seen = 1;
    end
    check("no_out_after_rst", seen, 0);
    do8(8'h05, 8'h03, 1, 0, 1, 0);

    for (int i = 0; i < 40; i++)
      do8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
          int'($urandom_range(0, 3)));

    do16(16'h0000, 16'h0001, 1, 0, 1);
    do16(16'h0000, 16'h0001, 1, 1, 1);
    for (int i = 0; i < 8; i++)
      do16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/addsub_digit_serial.md
ADDSUB_DIGIT_SERIAL -- requirements
Module: addsub_digit_serial

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter DIGIT, default 2, giving the bits processed per cycle; WIDTH mod DIGIT != 0 SHALL be an elaboration error.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: operands and mode are valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept a request.
REQ-007 The block SHALL have ports a and b, each input, WIDTH bits: unsigned operands.
REQ-008 The block SHALL have port sub, input, 1 bit: 0 selects add, 1 selects subtract.
REQ-009 The block SHALL have port sat, input, 1 bit: 1 selects saturating result.
REQ-010 The block SHALL have port cin, input, 1 bit: raw carry into the LSB (sub=1: 1 means no borrow-in).
REQ-011 The block SHALL have port out_valid, output, 1 bit: result and flags are valid.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-013 The block SHALL have port result, output, WIDTH bits: the sum or difference.
REQ-014 The block SHALL have port cout, output, 1 bit: the final MSB carry (sub=1: borrow-out = ~cout).
REQ-015 The block SHALL have port ovf, output, 1 bit: unsigned overflow (add) or underflow (sub).

Function
REQ-016 The FSM SHALL have states IDLE, RUN and DONE; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-017 In IDLE, in_valid=1 SHALL register a, b, sub, sat and cin, load the carry register with cin, clear the digit counter, and move to RUN.
REQ-018 Each RUN cycle SHALL add digit k of a to digit k of (sub ? ~b : b) plus the carry register, starting at the LSB digit, and SHALL store the sum digit and the new carry.
REQ-019 RUN SHALL last exactly N = WIDTH/DIGIT cycles, with the counter wrapping at N-1 into DONE, so out_valid rises N+1 rising edges after the accepting edge.
REQ-020 The raw result SHALL equal (a + (sub ? ~b : b) + cin) mod 2^WIDTH.
REQ-021 cout SHALL be the carry out of the MSB digit.
REQ-022 ovf SHALL equal cout when sub=0 and ~cout when sub=1.
REQ-023 When sat=1 and ovf=1, result SHALL be all ones for add and all zeros for subtract; ovf and cout SHALL still report the raw condition.
REQ-024 In DONE, result, cout and ovf SHALL be held stable until out_ready=1.
REQ-025 On the out_ready=1 edge in DONE the FSM SHALL return to IDLE, giving one bubble cycle between transactions.
REQ-026 in_valid and all operand inputs SHALL be ignored outside IDLE; changing them mid-operation SHALL NOT affect the active result.
REQ-027 out_ready SHALL be ignored outside DONE.
REQ-028 The ports a and b SHALL NOT feed result combinationally.

Reset
REQ-029 rst=1 SHALL immediately force IDLE, in_ready=1, out_valid=0, result=0, cout=0, ovf=0, and clear the counter and carry register, regardless of clk.
REQ-030 Reset asserted in RUN or DONE SHALL discard the transaction, and no out_valid SHALL follow it.
REQ-031 After rst deasserts, the first rising edge with in_valid=1 SHALL be accepted normally.

Verification (WIDTH=8, DIGIT=2 unless noted)
REQ-032 The bench SHALL cover: sub, a=0x50, b=0x20, cin=1, sat=0 -> out_valid 5 edges after accept; result=0x30, cout=1, ovf=0.
REQ-033 The bench SHALL cover: sub, a=0x10, b=0x20, cin=1 -> sat=0 gives result=0xF0, cout=0, ovf=1; sat=1 gives result=0x00, ovf=1.
REQ-034 The bench SHALL cover: add, a=0xF0, b=0x20, cin=0 -> sat=0 gives 0x10, cout=1, ovf=1; sat=1 gives 0xFF; add 0x7F+0x00 with cin=1 gives 0x80, ovf=0.
REQ-035 The bench SHALL cover: out_ready held 0 for 6 cycles in DONE while a new in_valid and new operands are driven -> result, flags and in_ready=0 hold; after out_ready=1, IDLE is entered and the new request is accepted next edge.
REQ-036 The bench SHALL cover: rst pulsed during the 2nd RUN cycle -> outputs take reset values asynchronously; a following sub 0x05-0x03, cin=1 gives 0x02, ovf=0.
REQ-037 The bench SHALL cover: WIDTH=16, DIGIT=1, sub 0x0000-0x0001, cin=1 -> 16 RUN cycles; result=0xFFFF, cout=0, ovf=1; with sat=1, result=0x0000.
